// File: rtl/set_repeat_control.sv
// Set-button controller: routes debounced button presses as one-cycle increment
// pulses to a selected channel, with hold-to-auto-repeat and timebase carry merge.
module set_repeat_control #(
  parameter int NCH      = 2,
  parameter int NBTN     = 2,
  parameter int SELW     = 1,
  parameter int HOLD_CYC = 1000,
  parameter int RPT_CYC  = 250,
  parameter int CW       = 16
) (
  input  logic                ck,
  input  logic                reset,
  input  logic [NBTN-1:0]     btn,
  input  logic [SELW-1:0]     sel,
  input  logic [NBTN-1:0]     carry_in,
  output logic [NCH*NBTN-1:0] up,
  output logic                busy
);

  localparam int IW = (NBTN > 1) ? $clog2(NBTN) : 1;

  typedef enum logic [2:0] {IDLE, FIRE, HOLD, RPT, REL} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic            rep;
  logic [IW-1:0]   idx;
  logic [SELW-1:0] ch;

  logic press_ok;
  logic held;
  logic hold_done;
  logic rpt_done;

  function automatic logic [IW-1:0] lowest_set(input logic [NBTN-1:0] v);
    lowest_set = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IW'(i);
    end
  endfunction

  assign press_ok  = (|btn) && (32'(sel) < NCH);
  assign held      = btn[idx];
  assign hold_done = (cnt == CW'(HOLD_CYC - 1));
  assign rpt_done  = (cnt == CW'(RPT_CYC - 1));

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge ck) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rep   <= 1'b0;
      idx   <= '0;
      ch    <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (press_ok) begin
            idx <= lowest_set(btn);
            ch  <= sel;
            rep <= 1'b0;
          end
        end
        FIRE: cnt <= '0;
        HOLD: begin
          cnt <= cnt + 1'b1;
          if (held && hold_done) rep <= 1'b1;
        end
        RPT:  cnt <= cnt + 1'b1;
        REL:  ;
        default: ;
      endcase
    end
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        // An out-of-range select still consumes the press so it cannot
        // re-trigger until every button has been released.
        if (press_ok)  next_state = FIRE;
        else if (|btn) next_state = REL;
      end
      FIRE: begin
        if (!held)    next_state = REL;
        else if (rep) next_state = RPT;
        else          next_state = HOLD;
      end
      HOLD: begin
        if (!held)          next_state = REL;
        else if (hold_done) next_state = FIRE;
      end
      RPT: begin
        if (!held)         next_state = REL;
        else if (rpt_done) next_state = FIRE;
      end
      REL: begin
        if (btn == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: manual pulse decoded from registers, carries merged on channel 0.
  always_comb begin
    up = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < NBTN; b++) begin
        up[c*NBTN+b] = (state == FIRE) && (ch == SELW'(c)) && (idx == IW'(b));
      end
    end
    up[NBTN-1:0] = up[NBTN-1:0] | carry_in;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_set_repeat_control.sv
// Directed bench for set_repeat_control: NCH=3, NBTN=2, HOLD_CYC=4, RPT_CYC=2,
// so sel=3 is the out-of-range select and up[5:0] = {ch2, ch1, ch0}.
module tb_set_repeat_control;

  localparam int NCH  = 3;
  localparam int NBTN = 2;
  localparam int SELW = 2;

  logic                ck = 1'b0;
  logic                reset;
  logic [NBTN-1:0]     btn;
  logic [SELW-1:0]     sel;
  logic [NBTN-1:0]     carry_in;
  logic [NCH*NBTN-1:0] up;
  logic                busy;

  int errors = 0;
  int checks = 0;

  set_repeat_control #(
    .NCH(NCH), .NBTN(NBTN), .SELW(SELW),
    .HOLD_CYC(4), .RPT_CYC(2), .CW(8)
  ) dut (
    .ck(ck), .reset(reset), .btn(btn), .sel(sel),
    .carry_in(carry_in), .up(up), .busy(busy)
  );

  always #5 ck = ~ck;

  // Advance one clock and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = '0; sel = '0; carry_in = '0;
    tick(); tick();
    checks++;
    if (up !== 6'b000000 || busy !== 1'b0) begin
      $display("FAIL reset_state: up=%b busy=%b expected up=000000 busy=0", up, busy);
      errors++;
    end
    carry_in = 2'b01; #1;
    checks++;
    if (up !== 6'b000001) begin
      $display("FAIL reset_carry0: up=%b expected 000001", up);
      errors++;
    end
    carry_in = 2'b10; #1;
    checks++;
    if (up !== 6'b000010) begin
      $display("FAIL reset_carry1: up=%b expected 000010", up);
      errors++;
    end
    carry_in = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_short_press();
    logic [5:0] exp_up [5]   = '{6'b000100, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
    logic       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sel = 2'd1; btn = 2'b01;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) btn = 2'b00;
      tick();
      checks++;
      if (up !== exp_up[i] || busy !== exp_busy[i]) begin
        $display("FAIL short_press cyc%0d: up=%b busy=%b expected up=%b busy=%b",
                 i, up, busy, exp_up[i], exp_busy[i]);
        errors++;
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic       pulse;
    logic [1:0] car;
    logic [5:0] exp;
    sel = 2'd0; btn = 2'b10;
    for (int i = 1; i <= 23; i++) begin
      if (i == 21) btn = 2'b00;
      car      = {(i == 6 || i == 7), (i % 3 == 0)};
      carry_in = car;
      tick();
      pulse = (i == 1 || i == 6 || i == 9 || i == 12 || i == 15 || i == 18);
      exp   = {4'b0000, pulse | car[1], car[0]};
      checks++;
      if (up !== exp) begin
        $display("FAIL auto_repeat cyc%0d: up=%b expected %b", i, up, exp);
        errors++;
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL auto_repeat_idle: busy=%b expected 0", busy);
      errors++;
    end
    carry_in = '0;
  endtask

  task automatic test_carry_pass();
    logic       pulse;
    logic [5:0] exp;
    sel = 2'd1; btn = 2'b01;
    for (int i = 1; i <= 11; i++) begin
      if (i == 3)  sel = 2'd0;
      if (i == 10) btn = 2'b00;
      carry_in = {1'b0, (i % 2 == 1)};
      tick();
      pulse = (i == 1 || i == 6 || i == 9);
      exp   = {3'b000, pulse, 1'b0, carry_in[0]};
      checks++;
      if (up !== exp) begin
        $display("FAIL carry_pass cyc%0d: up=%b expected %b", i, up, exp);
        errors++;
      end
    end
    carry_in = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL carry_pass_idle: busy=%b expected 0", busy);
      errors++;
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_up [12];
    logic       exp_busy [12];
    logic [1:0] drive [12];
    drive    = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                 2'b00, 2'b10, 2'b00, 2'b00};
    exp_up   = '{6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000010, 6'b000000, 6'b000000};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sel = 2'd0;
    for (int i = 0; i < 12; i++) begin
      btn = drive[i];
      tick();
      checks++;
      if (up !== exp_up[i] || busy !== exp_busy[i]) begin
        $display("FAIL simultaneous cyc%0d: up=%b busy=%b expected up=%b busy=%b",
                 i, up, busy, exp_up[i], exp_busy[i]);
        errors++;
      end
    end
  endtask

  task automatic test_select_bounds();
    sel = 2'd3; btn = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (up !== 6'b000000 || busy !== 1'b1) begin
        $display("FAIL sel_out_of_range cyc%0d: up=%b busy=%b expected up=000000 busy=1",
                 i, up, busy);
        errors++;
      end
    end
    btn = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL sel_out_of_range_idle: busy=%b expected 0", busy);
      errors++;
    end
    sel = 2'd2; btn = 2'b10;
    tick();
    checks++;
    if (up !== 6'b100000) begin
      $display("FAIL sel_top_channel: up=%b expected 100000", up);
      errors++;
    end
    btn = 2'b00;
    tick(); tick();
    checks++;
    if (up !== 6'b000000 || busy !== 1'b0) begin
      $display("FAIL sel_top_channel_idle: up=%b busy=%b expected up=000000 busy=0", up, busy);
      errors++;
    end
  endtask

  task automatic test_reset_mid_hold();
    sel = 2'd0; btn = 2'b01;
    tick();
    checks++;
    if (up !== 6'b000001) begin
      $display("FAIL rst_hold_first: up=%b expected 000001", up);
      errors++;
    end
    tick(); tick();
    reset = 1'b1; carry_in = 2'b10;
    tick();
    checks++;
    if (busy !== 1'b0 || up !== 6'b000010) begin
      $display("FAIL rst_hold_idle: up=%b busy=%b expected up=000010 busy=0", up, busy);
      errors++;
    end
    reset = 1'b0; carry_in = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b1 || up !== 6'b000001) begin
      $display("FAIL rst_hold_refire: up=%b busy=%b expected up=000001 busy=1", up, busy);
      errors++;
    end
    btn = 2'b00;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || up !== 6'b000000) begin
      $display("FAIL rst_hold_end: up=%b busy=%b expected up=000000 busy=0", up, busy);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_auto_repeat();
    test_carry_pass();
    test_simultaneous();
    test_select_bounds();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
